// File: rtl/serial_sub.sv
// ============================================================================
// Module   : serial_sub
// Brief    : Bit-serial unsigned subtractor, {bout, d} = a - b - bin, LSB first
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_d;
  logic          r_br;
  logic          r_bout;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_last;
  logic          w_bit;
  logic          w_br_nxt;
  logic [N-1:0]  w_d_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One full-subtractor cell; the result enters at the MSB so after N steps
  // the first (LSB) difference bit has reached position 0.
  always_comb begin
    w_bit            = r_a[0] ^ r_b[0] ^ r_br;
    w_br_nxt         = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_last           = (r_cnt == CW'(N - 1));
    w_d_shift        = r_d >> 1;
    w_d_shift[N-1]   = w_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a  <= r_a >> 1;
      r_b  <= r_b >> 1;
      r_br <= w_br_nxt;
      r_d  <= w_d_shift;
      // Counter stops at N-1 rather than wrapping.
      if (w_last) begin
        r_bout <= w_br_nxt;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign d    = r_d;
  assign bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// ============================================================================
// Module   : tb_serial_sub
// Brief    : Self-checking bench for serial_sub against an arithmetic model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub;

  localparam int N = 5;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin       = 1'b0;
  logic [N-1:0] a         = '0;
  logic [N-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] d;
  logic         bout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  serial_sub #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer subtraction folded into N+1 bits.
  function automatic logic [N:0] ref_sub(input int x, input int y, input int z);
    int r;
    r = (x - y - z) & ((1 << (N + 1)) - 1);
    return r[N:0];
  endfunction

  // Presents one operation and waits for its result; called 1 time unit
  // after a rising edge.
  task automatic run_op(input int xa, input int xb, input int xbin, input bit keep,
                        output logic [N-1:0] rd, output logic rbo,
                        output int acc_cyc, output int lat,
                        output logic ir_after, output bit ok);
    int n;
    ok       = 1'b1;
    a        = xa[N-1:0];
    b        = xb[N-1:0];
    bin      = xbin[0];
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) ok = 1'b0;
    acc_cyc = cyc;
    @(posedge clk); #1;
    ir_after = in_ready;
    if (!keep) in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) ok = 1'b0;
    lat = n;
    rd  = d;
    rbo = bout;
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready, out_valid, d, bout} !== {1'b1, 1'b0, {N{1'b0}}, 1'b0}) begin
      fails++;
      $display("FAIL reset: got in_ready=%b out_valid=%b d=%0d bout=%b want 1 0 0 0",
               in_ready, out_valid, d, bout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [N-1:0] rd; logic rbo, ira; int acc, lat; bit ok;
    out_ready = 1'b1;
    run_op(13, 6, 0, 1'b0, rd, rbo, acc, lat, ira, ok);
    tests++;
    if (ira !== 1'b0) begin
      fails++; $display("FAIL basic_in_ready_drop: got %b want 0", ira);
    end
    tests++;
    if (!ok || lat != N) begin
      fails++; $display("FAIL basic_latency: got %0d want %0d (ok=%0d)", lat, N, ok);
    end
    tests++;
    if ({rbo, rd} !== {1'b0, 5'd7}) begin
      fails++; $display("FAIL basic_result: got d=%0d bout=%b want d=7 bout=0", rd, rbo);
    end
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_borrow();
    int tab[3][5] = '{'{3, 5, 1, 29, 1}, '{0, 0, 1, 31, 1}, '{31, 31, 0, 0, 0}};
    logic [N-1:0] rd; logic rbo, ira; int acc, lat; bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(tab[i][0], tab[i][1], tab[i][2], 1'b0, rd, rbo, acc, lat, ira, ok);
      tests++;
      if (!ok || rd !== tab[i][3][N-1:0] || rbo !== tab[i][4][0]) begin
        fails++;
        $display("FAIL borrow a=%0d b=%0d bin=%0d: got d=%0d bout=%b want d=%0d bout=%0d",
                 tab[i][0], tab[i][1], tab[i][2], rd, rbo, tab[i][3], tab[i][4]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rd; logic rbo, ira; int acc, lat; bit ok, bad;
    out_ready = 1'b0;
    run_op(20, 4, 0, 1'b0, rd, rbo, acc, lat, ira, ok);
    tests++;
    if (!ok || {rbo, rd} !== {1'b0, 5'd16}) begin
      fails++; $display("FAIL bp_result: got d=%0d bout=%b want d=16 bout=0", rd, rbo);
    end
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || d !== 5'd16 || bout !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL bp_hold: got out_valid=%b d=%0d bout=%b in_ready=%b want 1 16 0 0",
               out_valid, d, bout, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    logic [N-1:0] rd; logic rbo, ira; int acc, lat; bit ok, seen;
    out_ready = 1'b1;
    a = 5'd27; b = 5'd6; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, d, bout} !== {1'b1, 1'b0, {N{1'b0}}, 1'b0}) begin
      fails++;
      $display("FAIL abort_async: got in_ready=%b out_valid=%b d=%0d bout=%b want 1 0 0 0",
               in_ready, out_valid, d, bout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (seen) begin
      fails++; $display("FAIL abort_no_result: got out_valid=1 want 0");
    end
    run_op(9, 2, 0, 1'b0, rd, rbo, acc, lat, ira, ok);
    tests++;
    if (!ok || {rbo, rd} !== {1'b0, 5'd7}) begin
      fails++; $display("FAIL abort_next: got d=%0d bout=%b want d=7 bout=0", rd, rbo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] rd; logic rbo, ira; int acc, lat, prev; bit ok;
    logic [N:0] exp;
    out_ready = 1'b1;
    prev = -1;
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        for (int z = 0; z < 2; z++) begin
          run_op(x, y, z, 1'b1, rd, rbo, acc, lat, ira, ok);
          exp = ref_sub(x, y, z);
          tests++;
          if (!ok || {rbo, rd} !== exp) begin
            fails++;
            $display("FAIL b2b a=%0d b=%0d bin=%0d: got bout=%b d=%0d want bout=%b d=%0d",
                     x, y, z, rbo, rd, exp[N], exp[N-1:0]);
          end
          if (prev >= 0) begin
            tests++;
            if (acc - prev != N + 2) begin
              fails++;
              $display("FAIL b2b_spacing a=%0d b=%0d bin=%0d: got %0d want %0d",
                       x, y, z, acc - prev, N + 2);
            end
          end
          prev = acc;
        end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [N-1:0] rd; logic rbo, ira; int acc, lat, x, y, z, hold; bit ok, bad;
    logic [N:0] exp;
    for (int i = 0; i < 200; i++) begin
      x = $urandom_range(31); y = $urandom_range(31); z = $urandom_range(1);
      hold = $urandom_range(3);
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      run_op(x, y, z, 1'b0, rd, rbo, acc, lat, ira, ok);
      exp = ref_sub(x, y, z);
      bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
        a = N'($urandom); b = N'($urandom); in_valid = 1'b1;
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || {bout, d} !== {rbo, rd}) bad = 1'b1;
      end
      in_valid = 1'b0;
      tests++;
      if (!ok || bad || {rbo, rd} !== exp) begin
        fails++;
        $display("FAIL rand a=%0d b=%0d bin=%0d: got bout=%b d=%0d want bout=%b d=%0d held=%0d",
                 x, y, z, rbo, rd, exp[N], exp[N-1:0], !bad);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_trip();
    logic [N-1:0] rd; logic rbo, ira; int acc, lat, s; bit ok;
    out_ready = 1'b1;
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++) begin
        s = x + y;
        if (s < 32) begin
          run_op(s, y, 0, 1'b1, rd, rbo, acc, lat, ira, ok);
          tests++;
          if (!ok || rd !== x[N-1:0] || rbo !== 1'b0) begin
            fails++;
            $display("FAIL round_trip a=%0d b=%0d: got d=%0d bout=%b want d=%0d bout=0",
                     x, y, rd, rbo, x);
          end
        end
      end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_random();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
